// File: rtl/moller_axil_regfile_slave.sv
// AXI4-Lite register file responder for the MOLLER register map.
// Holds NUM_REGS 32-bit registers with byte-strobe writes, OKAY/SLVERR
// responses, and exposes register contents plus per-register write pulses.
module moller_axil_regfile_slave #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_REGS   = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [0:0]       w_state;
  logic [0:0]       r_state;
  logic             aw_captured;
  logic             w_captured;
  logic [IDX_W-1:0] aw_idx;
  logic [31:0]      wdata_hold;
  logic [3:0]       wstrb_hold;
  logic [31:0]      regs [NUM_REGS];

  logic             aw_fire;
  logic             w_fire;
  logic             wr_commit;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             ar_fire;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_word;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < (IDX_W + 1)'(NUM_REGS);
  endfunction

  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Ready signals come only from registered state, never from a VALID.
  assign S_AXI_AWREADY = (w_state == W_IDLE) && !aw_captured;
  assign S_AXI_WREADY  = (w_state == W_IDLE) && !w_captured;
  assign S_AXI_ARREADY = (r_state == R_IDLE);

  assign aw_fire   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire    = S_AXI_WVALID && S_AXI_WREADY;
  assign wr_commit = (w_state == W_IDLE) && (aw_captured || aw_fire) && (w_captured || w_fire);
  assign wr_idx    = aw_captured ? aw_idx : S_AXI_AWADDR[ADDR_WIDTH-1:2];
  assign wr_data   = w_captured ? wdata_hold : S_AXI_WDATA;
  assign wr_strb   = w_captured ? wstrb_hold : S_AXI_WSTRB;
  assign ar_fire   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx    = S_AXI_ARADDR[ADDR_WIDTH-1:2];

  // Read mux; an out-of-range index falls through to zero.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IDX_W'(k)) rd_word = regs[k];
    end
  end

  // Write channel FSM: capture AW and W independently, respond once both are in.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state      <= W_IDLE;
      aw_captured  <= 1'b0;
      w_captured   <= 1'b0;
      aw_idx       <= '0;
      wdata_hold   <= '0;
      wstrb_hold   <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_captured <= 1'b1;
            aw_idx      <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
          end
          if (w_fire) begin
            w_captured <= 1'b1;
            wdata_hold <= S_AXI_WDATA;
            wstrb_hold <= S_AXI_WSTRB;
          end
          if (wr_commit) begin
            w_state      <= W_RESP;
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= in_range(wr_idx) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: begin
          if (S_AXI_BREADY) begin
            w_state      <= W_IDLE;
            S_AXI_BVALID <= 1'b0;
            aw_captured  <= 1'b0;
            w_captured   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Register array update and the matching one-cycle write pulse.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_wr_pulse[k] <= wr_commit && (wr_idx == IDX_W'(k));
        if (wr_commit && (wr_idx == IDX_W'(k))) begin
          regs[k] <= apply_strobe(regs[k], wr_data, wr_strb);
        end
      end
    end
  end

  // Read channel FSM: one-cycle latency, data held until RREADY.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_state      <= R_DATA;
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_word;
            S_AXI_RRESP  <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        default: begin
          if (S_AXI_RREADY) begin
            r_state      <= R_IDLE;
            S_AXI_RVALID <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_q
    assign reg_q[32*k +: 32] = regs[k];
  end

endmodule

// File: tb/tb_moller_axil_regfile_slave.sv
// Self-checking bench for moller_axil_regfile_slave: directed scenarios
// followed by randomized traffic against a word-array reference model.
module tb_moller_axil_regfile_slave;

  localparam int ADDR_WIDTH = 6;
  localparam int NUM_REGS   = 4;

  logic                   clk;
  logic                   rst;
  logic [ADDR_WIDTH-1:0]  awaddr;
  logic [2:0]             awprot;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [ADDR_WIDTH-1:0]  araddr;
  logic [2:0]             arprot;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic [NUM_REGS*32-1:0] reg_q;
  logic [NUM_REGS-1:0]    reg_wr_pulse;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [NUM_REGS];

  moller_axil_regfile_slave #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REGS*32-1:0] packed_model();
    logic [NUM_REGS*32-1:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return m;
  endfunction

  task automatic do_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly);
    int idx;
    bit inr;
    logic [NUM_REGS-1:0] exp_pulse;
    logic [1:0] exp_resp;
    idx = int'(addr[ADDR_WIDTH-1:2]);
    inr = idx < NUM_REGS;
    fork
      begin
        bit seen;
        if (aw_dly > 0) begin repeat (aw_dly) @(posedge clk); #1; end
        awaddr = addr; awvalid = 1'b1;
        for (int c = 0; ; c++) begin
          @(negedge clk); seen = awready;
          @(posedge clk); #1;
          if (seen) break;
          if (c >= 100) begin check("aw_timeout", awready, 1); break; end
        end
        awvalid = 1'b0;
        check("awready_after_aw", awready, 0);
      end
      begin
        bit seen;
        if (w_dly > 0) begin repeat (w_dly) @(posedge clk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int c = 0; ; c++) begin
          @(negedge clk); seen = wready;
          @(posedge clk); #1;
          if (seen) break;
          if (c >= 100) begin check("w_timeout", wready, 1); break; end
        end
        wvalid = 1'b0;
        check("wready_after_w", wready, 0);
      end
    join
    exp_pulse = '0;
    if (inr) begin
      model[idx] = merge(model[idx], data, strb);
      exp_pulse[idx] = 1'b1;
    end
    exp_resp = inr ? 2'b00 : 2'b10;
    check("bvalid_rise", bvalid, 1);
    check("bresp", bresp, exp_resp);
    check("wr_pulse", reg_wr_pulse, exp_pulse);
    check("reg_q_after_wr", reg_q, packed_model());
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, exp_resp);
      check("ready_in_resp", {awready, wready}, 2'b00);
      check("wr_pulse_once", reg_wr_pulse, 0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_fall", bvalid, 0);
    check("ready_after_b", {awready, wready}, 2'b11);
    check("wr_pulse_clear", reg_wr_pulse, 0);
  endtask

  task automatic do_read(input logic [ADDR_WIDTH-1:0] addr, input int r_dly);
    int idx;
    bit seen;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    idx = int'(addr[ADDR_WIDTH-1:2]);
    exp_resp = (idx < NUM_REGS) ? 2'b00 : 2'b10;
    araddr = addr; arvalid = 1'b1;
    exp_data = '0;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      seen = arready;
      exp_data = (idx < NUM_REGS) ? model[idx] : 32'h0;
      @(posedge clk); #1;
      if (seen) break;
      if (c >= 100) begin check("ar_timeout", arready, 1); break; end
    end
    arvalid = 1'b0;
    check("rvalid_rise", rvalid, 1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    check("arready_in_data", arready, 0);
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); #1;
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, exp_data);
      check("arready_hold", arready, 0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_fall", rvalid, 0);
    check("arready_back", arready, 1);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_readys", {awready, wready, arready}, 3'b111);
    check("rst_reg_q", reg_q, 0);
    check("rst_resp_data", {bresp, rresp, rdata}, 0);
    check("rst_pulse", reg_wr_pulse, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill all four registers and read them back.
    for (int k = 0; k < NUM_REGS; k++) do_write(ADDR_WIDTH'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
    for (int k = 0; k < NUM_REGS; k++) do_read(ADDR_WIDTH'(4 * k), 0);
    check("reg_q_fill", reg_q, 128'h00000004_00000003_00000002_00000001);

    // Byte strobes.
    do_write(6'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(6'h04, 32'h12345678, 4'b0101, 1, 0, 0);
    do_read(6'h04, 0);
    check("strobe_merge", reg_q[63:32], 32'hFF34FF78);

    // Zero strobe still pulses, leaves data alone.
    do_write(6'h04, 32'h0, 4'h0, 0, 0, 0);

    // W three cycles ahead of AW.
    do_write(6'h08, 32'hA5A5A5A5, 4'hF, 3, 0, 0);
    check("w_first_reg2", reg_q[95:64], 32'hA5A5A5A5);

    // Out of range write and read.
    do_write(6'h10, 32'hDEADBEEF, 4'hF, 0, 2, 0);
    do_read(6'h3C, 0);

    // Backpressure on B and R.
    do_write(6'h0C, 32'h0BADF00D, 4'hF, 0, 0, 5);
    do_read(6'h0C, 5);

    // Same-edge read and write commit to one register returns the old value.
    fork
      do_write(6'h00, 32'hCAFEF00D, 4'hF, 0, 0, 0);
      do_read(6'h00, 0);
    join
    do_read(6'h00, 0);

    // Reset between AW and W handshakes.
    awaddr = 6'h00; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_taken", awready, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_readys", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    @(posedge clk); #1;
    check("post_rst_bvalid", bvalid, 0);
    check("post_rst_readys", {awready, wready, arready}, 3'b111);
    check("post_rst_reg_q", reg_q, 0);
    check("post_rst_pulse", reg_wr_pulse, 0);
    do_write(6'h00, 32'h13579BDF, 4'hF, 0, 1, 1);
    do_read(6'h00, 1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [ADDR_WIDTH-1:0] a;
      logic [ADDR_WIDTH-1:0] ra;
      int op;
      a  = ($urandom_range(0, 3) != 0) ? ADDR_WIDTH'($urandom_range(0, 4 * NUM_REGS - 1))
                                       : ADDR_WIDTH'($urandom_range(0, 63));
      ra = ADDR_WIDTH'($urandom_range(0, 4 * NUM_REGS + 3));
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      end else if (op == 1) begin
        do_read(ra, $urandom_range(0, 2));
      end else begin
        fork
          do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2));
          do_read(ra, $urandom_range(0, 2));
        join
      end
    end
    check("final_reg_q", reg_q, packed_model());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
